// File: rtl/cache_pkg.sv
// cache_pkg: shared L1 cache geometry defaults and init FSM state type.
package cache_pkg;
    localparam int L1_LINE_WIDTH = 32;
    localparam int L1_TAG_BITS   = 21;
    localparam int L1_INDEX_BITS = 9;
    typedef enum logic {INIT, READY} init_state_t;
endpackage

// File: rtl/l1_way_store.sv
// l1_way_store: one cache way of {valid, dirty, tag, data} with async read, sync write and sweep clear.
module l1_way_store import cache_pkg::*; #(
    parameter int LINE_WIDTH = L1_LINE_WIDTH,
    parameter int TAG_BITS   = L1_TAG_BITS,
    parameter int INDEX_BITS = L1_INDEX_BITS
) (
    input  logic                  clk,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic [LINE_WIDTH-1:0] rd_data,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [LINE_WIDTH-1:0] wr_data,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic                  clr_en,
    input  logic [INDEX_BITS-1:0] clr_index
);
    localparam int SETS = 2**INDEX_BITS;
    logic [LINE_WIDTH-1:0] data_q  [SETS];
    logic [TAG_BITS-1:0]   tag_q   [SETS];
    logic                  valid_q [SETS];
    logic                  dirty_q [SETS];
    // Clear owns the port during the sweep; the top never raises both together.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            valid_q[clr_index] <= 1'b0;
            dirty_q[clr_index] <= 1'b0;
        end else if (wr_en) begin
            data_q[wr_index]  <= wr_data;
            tag_q[wr_index]   <= wr_tag;
            valid_q[wr_index] <= wr_valid;
            dirty_q[wr_index] <= wr_dirty;
        end
    end
    assign rd_data  = data_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
endmodule

// File: rtl/l1_cache_array.sv
// l1_cache_array: two-way L1 data-cache storage with LRU bits and a post-reset invalidation sweep.
module l1_cache_array import cache_pkg::*; #(
    parameter int LINE_WIDTH = L1_LINE_WIDTH,
    parameter int TAG_BITS   = L1_TAG_BITS,
    parameter int INDEX_BITS = L1_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] L1_read_index,
    output logic [LINE_WIDTH-1:0] L1_data_way0,
    output logic [LINE_WIDTH-1:0] L1_data_way1,
    output logic [TAG_BITS-1:0]   L1_tag_way0,
    output logic [TAG_BITS-1:0]   L1_tag_way1,
    output logic                  L1_valid_way0,
    output logic                  L1_valid_way1,
    output logic                  L1_dirty_way0,
    output logic                  L1_dirty_way1,
    output logic                  L1_lru_bit,
    input  logic                  L1_write_en_way0,
    input  logic                  L1_write_en_way1,
    input  logic [INDEX_BITS-1:0] L1_write_index,
    input  logic [LINE_WIDTH-1:0] L1_write_data_way0,
    input  logic [LINE_WIDTH-1:0] L1_write_data_way1,
    input  logic [TAG_BITS-1:0]   L1_write_tag_way0,
    input  logic [TAG_BITS-1:0]   L1_write_tag_way1,
    input  logic                  L1_write_valid_way0,
    input  logic                  L1_write_valid_way1,
    input  logic                  L1_write_dirty_way0,
    input  logic                  L1_write_dirty_way1,
    input  logic                  L1_write_lru,
    input  logic                  L1_lru_value,
    output logic                  init_busy
);
    localparam int SETS = 2**INDEX_BITS;
    localparam logic [INDEX_BITS-1:0] LAST = '1;
    init_state_t           state, state_n;
    logic [INDEX_BITS-1:0] cnt, cnt_n;
    logic                  lru_q [SETS];
    logic [LINE_WIDTH-1:0] d0, d1;
    logic [TAG_BITS-1:0]   t0, t1;
    logic                  v0, v1, y0, y1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (state == INIT) begin
            state_n = (cnt == LAST) ? READY : INIT;
            cnt_n   = (cnt == LAST) ? cnt : cnt + 1'b1;
        end
    end
    assign init_busy = (state == INIT);
    always_ff @(posedge clk) begin
        if (init_busy)
            lru_q[cnt] <= 1'b0;
        else if (L1_write_lru)
            lru_q[L1_write_index] <= L1_lru_value;
    end
    l1_way_store #(.LINE_WIDTH(LINE_WIDTH), .TAG_BITS(TAG_BITS), .INDEX_BITS(INDEX_BITS)) u_way0 (
        .clk(clk), .rd_index(L1_read_index), .rd_data(d0), .rd_tag(t0), .rd_valid(v0), .rd_dirty(y0),
        .wr_en(L1_write_en_way0 & ~init_busy), .wr_index(L1_write_index), .wr_data(L1_write_data_way0),
        .wr_tag(L1_write_tag_way0), .wr_valid(L1_write_valid_way0), .wr_dirty(L1_write_dirty_way0),
        .clr_en(init_busy), .clr_index(cnt)
    );
    l1_way_store #(.LINE_WIDTH(LINE_WIDTH), .TAG_BITS(TAG_BITS), .INDEX_BITS(INDEX_BITS)) u_way1 (
        .clk(clk), .rd_index(L1_read_index), .rd_data(d1), .rd_tag(t1), .rd_valid(v1), .rd_dirty(y1),
        .wr_en(L1_write_en_way1 & ~init_busy), .wr_index(L1_write_index), .wr_data(L1_write_data_way1),
        .wr_tag(L1_write_tag_way1), .wr_valid(L1_write_valid_way1), .wr_dirty(L1_write_dirty_way1),
        .clr_en(init_busy), .clr_index(cnt)
    );
    // Storage is not reset, so everything read out is masked until the sweep finishes.
    assign L1_data_way0  = init_busy ? '0 : d0;
    assign L1_data_way1  = init_busy ? '0 : d1;
    assign L1_tag_way0   = init_busy ? '0 : t0;
    assign L1_tag_way1   = init_busy ? '0 : t1;
    assign L1_valid_way0 = init_busy ? 1'b0 : v0;
    assign L1_valid_way1 = init_busy ? 1'b0 : v1;
    assign L1_dirty_way0 = init_busy ? 1'b0 : y0;
    assign L1_dirty_way1 = init_busy ? 1'b0 : y1;
    assign L1_lru_bit    = init_busy ? 1'b0 : lru_q[L1_read_index];
endmodule

// File: tb/tb_l1_cache_array.sv
// tb_l1_cache_array: directed self-checking bench for l1_cache_array.
module tb_l1_cache_array;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [8:0]  rd_idx = '0, wr_idx = '0;
    logic [31:0] data0, data1, wd0 = '0, wd1 = '0;
    logic [20:0] tag0, tag1, wt0 = '0, wt1 = '0;
    logic        val0, val1, dty0, dty1, lru, busy;
    logic        we0 = 0, we1 = 0, wv0 = 0, wv1 = 0, wy0 = 0, wy1 = 0, wlru = 0, lru_val = 0;
    int          n_checks = 0, n_fail = 0;
    int          cycles, bad;

    always #5 clk = ~clk;

    l1_cache_array dut (
        .clk(clk), .rst_n(rst_n), .L1_read_index(rd_idx),
        .L1_data_way0(data0), .L1_data_way1(data1), .L1_tag_way0(tag0), .L1_tag_way1(tag1),
        .L1_valid_way0(val0), .L1_valid_way1(val1), .L1_dirty_way0(dty0), .L1_dirty_way1(dty1),
        .L1_lru_bit(lru), .L1_write_en_way0(we0), .L1_write_en_way1(we1), .L1_write_index(wr_idx),
        .L1_write_data_way0(wd0), .L1_write_data_way1(wd1), .L1_write_tag_way0(wt0), .L1_write_tag_way1(wt1),
        .L1_write_valid_way0(wv0), .L1_write_valid_way1(wv1), .L1_write_dirty_way0(wy0), .L1_write_dirty_way1(wy1),
        .L1_write_lru(wlru), .L1_lru_value(lru_val), .init_busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic e0, input logic e1, input logic le, input logic lv, input logic [8:0] idx,
                            input logic [31:0] d0, input logic [31:0] d1, input logic [20:0] t0, input logic [20:0] t1,
                            input logic v0, input logic y0, input logic v1, input logic y1);
        we0 = e0; we1 = e1; wlru = le; lru_val = lv; wr_idx = idx;
        wd0 = d0; wd1 = d1; wt0 = t0; wt1 = t1; wv0 = v0; wy0 = y0; wv1 = v1; wy1 = y1;
        @(posedge clk);
        #1;
        we0 = 0; we1 = 0; wlru = 0;
    endtask

    task automatic wait_sweep(input string tag);
        cycles = 0;
        while (busy && cycles < 1000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        we0 = 0; we1 = 0; wlru = 0;
        check(tag, 64'(cycles), 64'd512);
    endtask

    task automatic read_at(input logic [8:0] idx);
        rd_idx = idx;
        #1;
    endtask

    initial begin
        rd_idx = 9'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd1);
        check("rst_mask", {data0, tag0, val1, dty1, lru}, 64'd0);
        rst_n = 1'b1;
        wait_sweep("sweep_len");
        bad = 0;
        for (int i = 0; i < 512; i++) begin
            read_at(9'(i));
            if (val0 | val1 | dty0 | dty1 | lru) bad++;
        end
        check("scan_clear", 64'(bad), 64'd0);
        @(negedge clk);

        do_write(1, 0, 0, 0, 9'd5, 32'hDEADBEEF, 32'h0, 21'h1ABCD, 21'h0, 1, 1, 0, 0);
        read_at(9'd5);
        check("w5_data0", 64'(data0), 64'hDEADBEEF);
        check("w5_tag0", 64'(tag0), 64'h1ABCD);
        check("w5_vd0", {val0, dty0}, 64'd3);
        check("w5_val1", 64'(val1), 64'd0);
        read_at(9'd6);
        check("i6_val0", 64'(val0), 64'd0);

        do_write(1, 1, 1, 1, 9'd7, 32'h11111111, 32'h22222222, 21'h7, 21'h8, 1, 0, 1, 0);
        read_at(9'd7);
        check("w7_data0", 64'(data0), 64'h11111111);
        check("w7_data1", 64'(data1), 64'h22222222);
        check("w7_lru1", 64'(lru), 64'd1);
        do_write(0, 0, 1, 0, 9'd7, 32'h0, 32'h0, 21'h0, 21'h0, 0, 0, 0, 0);
        read_at(9'd7);
        check("lru_only_data", {data0, data1}, 64'h11111111_22222222);
        check("lru_only_lru", 64'(lru), 64'd0);

        do_write(1, 0, 0, 0, 9'd9, 32'hAAAA0000, 32'h0, 21'h9, 21'h0, 1, 0, 0, 0);
        rd_idx = 9'd9;
        we0 = 1; wr_idx = 9'd9; wd0 = 32'h5555FFFF; wt0 = 21'h9; wv0 = 1; wy0 = 1;
        #1;
        check("rdw_old", 64'(data0), 64'hAAAA0000);
        @(posedge clk);
        #1;
        we0 = 0;
        check("rdw_new", 64'(data0), 64'h5555FFFF);

        do_write(0, 1, 0, 0, 9'd400, 32'h0, 32'h40040040, 21'h0, 21'h190, 0, 0, 1, 1);
        read_at(9'd400);
        check("w400_val1", 64'(val1), 64'd1);

        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        we0 = 1; wlru = 1; lru_val = 1; wr_idx = 9'd20; wv0 = 1; wy0 = 1; wd0 = 32'hCAFE0020;
        repeat (200) @(negedge clk);
        check("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        read_at(9'd9);
        check("mid_mask", {data0, val0, dty0}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wr_idx = 9'd30;
        wait_sweep("resweep_len");
        read_at(9'd400);
        check("i400_val1", 64'(val1), 64'd0);
        read_at(9'd20);
        check("i20_init_wr", {val0, dty0, lru}, 64'd0);
        read_at(9'd30);
        check("i30_edge_wr", {val0, dty0, lru}, 64'd0);
        read_at(9'd9);
        check("i9_val0", 64'(val0), 64'd0);
        check("ready_busy", 64'(busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
